// File: rtl/alu_arbiter_if.sv
// Bundle between the two ALU requesters, the arbiter and the shared ALU.
// slave: the arbiter's view; master: the requesters plus the ALU it drives.
interface alu_arbiter_if;
  logic        req0, req1;
  logic [4:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic [4:0]  shamt0, shamt1;
  logic        gnt0, gnt1;
  logic        done0, done1;

  logic [4:0]  alu_opcode;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_ovf, alu_ne, alu_lt;

  logic [31:0] result;
  logic        ovf, ne, lt, err;
  logic        busy;
  logic [15:0] cnt0, cnt1;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, shamt0, shamt1,
    input  alu_result, alu_ovf, alu_ne, alu_lt,
    output gnt0, gnt1, done0, done1,
    output alu_opcode, alu_a, alu_b, alu_shamt,
    output result, ovf, ne, lt, err, busy, cnt0, cnt1
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, shamt0, shamt1,
    output alu_result, alu_ovf, alu_ne, alu_lt,
    input  gnt0, gnt1, done0, done1,
    input  alu_opcode, alu_a, alu_b, alu_shamt,
    input  result, ovf, ne, lt, err, busy, cnt0, cnt1
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; ALU_ARB_STATS_EN adds saturating done counters.
// Latency: gnt one cycle after the request edge, done one cycle later; requesters hold req until gnt, no queuing.
module alu_arbiter (
  input logic          clock,
  input logic          reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  logic [4:0]  op_q;
  logic [4:0]  shamt_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        owner_q;
  logic        last_q;
  logic        gnt0_q, gnt1_q;
  logic        done0_q, done1_q;
  logic        busy_q;
  logic [31:0] result_q;
  logic        ovf_q, ne_q, lt_q, err_q;

  logic        any_req;
  logic        winner;
  logic        op_legal;
  logic        op_addsub;
  logic        op_sub;
  logic        in_exec;

  assign any_req   = bus.req0 | bus.req1;
  // last_q resets to 1 so requester 0 wins the first tie.
  assign winner    = (bus.req0 & bus.req1) ? ~last_q : ~bus.req0;
  assign op_legal  = (op_q <= 5'd5);
  assign op_addsub = (op_q[4:1] == 4'd0);
  assign op_sub    = (op_q == 5'd1);
  assign in_exec   = (state == EXEC);

  assign bus.alu_opcode = in_exec ? op_q    : 5'd0;
  assign bus.alu_a      = in_exec ? a_q     : 32'd0;
  assign bus.alu_b      = in_exec ? b_q     : 32'd0;
  assign bus.alu_shamt  = in_exec ? shamt_q : 5'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= 5'd0;
      shamt_q  <= 5'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= 32'd0;
      ovf_q    <= 1'b0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          if (any_req) begin
            state   <= EXEC;
            busy_q  <= 1'b1;
            owner_q <= winner;
            last_q  <= winner;
            gnt0_q  <= ~winner;
            gnt1_q  <= winner;
            op_q    <= winner ? bus.op1    : bus.op0;
            a_q     <= winner ? bus.a1     : bus.a0;
            b_q     <= winner ? bus.b1     : bus.b0;
            shamt_q <= winner ? bus.shamt1 : bus.shamt0;
          end
        end
        EXEC: begin
          state    <= RESP;
          gnt0_q   <= 1'b0;
          gnt1_q   <= 1'b0;
          done0_q  <= ~owner_q;
          done1_q  <= owner_q;
          // Flags the op does not define are masked so ALU junk never leaks out.
          result_q <= op_legal ? bus.alu_result : 32'd0;
          ovf_q    <= op_addsub & bus.alu_ovf;
          ne_q     <= op_sub & bus.alu_ne;
          lt_q     <= op_sub & bus.alu_lt;
          err_q    <= ~op_legal;
        end
        RESP: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.busy   = busy_q;
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
  assign bus.ne     = ne_q;
  assign bus.lt     = lt_q;
  assign bus.err    = err_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  // Counted on the edge that raises done, so the count moves with the pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else if (in_exec) begin
      if (!owner_q && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (owner_q && cnt1_q != 16'hFFFF)  cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;
`else
  assign bus.cnt0 = 16'd0;
  assign bus.cnt1 = 16'd0;
`endif

endmodule
